ex_stage_pipe: RTL and testbench

Parametrised execute stage with valid/ready handshakes on both sides and operand forwarding from MEM and WB. It adds an optional iterative multiplier beside the single-cycle ALU. It sits between the ID/EX boundary and the MEM stage, and it owns the EX/MEM pipeline register. It instantiates the existing combinational `alu` and adds stall, flush and multi-cycle behaviour.

---
 rtl/ex_stage_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding muxes, operand select, ALU and the EX/MEM register with valid/ready handshakes.
// Optional iterative unsigned multiplier (MUL / MULHU) enabled by defining EX_MUL_EN.

module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] y
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass b
  always_comb begin
    y = '0;
    case (func)
      4'd0:    y = a + b;
      4'd1:    y = a - b;
      4'd2:    y = a << shamt;
      4'd3:    y = WIDTH'($signed(a) < $signed(b));
      4'd4:    y = WIDTH'(a < b);
      4'd5:    y = a ^ b;
      4'd6:    y = a >> shamt;
      4'd7:    y = WIDTH'($signed(a) >>> shamt);
      4'd8:    y = a | b;
      4'd9:    y = a & b;
      4'd10:   y = b;
      default: y = '0;
    endcase
  end
endmodule

module ex_stage_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          opsel1,
  input  logic [1:0]          opsel2,
  input  logic [1:0]          fwd1_sel,
  input  logic [1:0]          fwd2_sel,
  input  logic [3:0]          alu_func,
  input  logic [1:0]          mul_op,
  input  logic [WIDTH-1:0]    rs1_data,
  input  logic [WIDTH-1:0]    rs2_data,
  input  logic [WIDTH-1:0]    imm,
  input  logic [WIDTH-1:0]    mem_fwd,
  input  logic [WIDTH-1:0]    wb_fwd,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [WIDTH-1:0]    alu_out,
  output logic [WIDTH-1:0]    rs2_o
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    rs1_fwd, rs2_fwd, op1, op2, alu_y;
  logic [WIDTH-1:0]    res_d, rs2_d;
  logic [ADDR_LEN-1:0] pc_d;
  logic                out_free, accept, load;

  // Forwarding first, then operand select
  always_comb begin
    case (fwd1_sel)
      2'd1:    rs1_fwd = mem_fwd;
      2'd2:    rs1_fwd = wb_fwd;
      default: rs1_fwd = rs1_data;
    endcase
    case (fwd2_sel)
      2'd1:    rs2_fwd = mem_fwd;
      2'd2:    rs2_fwd = wb_fwd;
      default: rs2_fwd = rs2_data;
    endcase
    case (opsel1)
      2'd0:    op1 = rs1_fwd;
      2'd1:    op1 = WIDTH'(pc_i);
      default: op1 = '0;
    endcase
    case (opsel2)
      2'd0:    op2 = rs2_fwd;
      2'd1:    op2 = imm;
      2'd2:    op2 = WIDTH'(4);
      default: op2 = '0;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (op1),
    .b    (op2),
    .func (alu_func),
    .y    (alu_y)
  );

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == IDLE) && out_free && !flush && !reset;
  assign accept   = in_valid && in_ready;

`ifdef EX_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0]  mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d, mrs2_q, mrs2_d;
  logic [ADDR_LEN-1:0] mpc_q, mpc_d;
  logic [CW-1:0]       count_q, count_d;
  logic                mul_hi_q, mul_hi_d;
  logic                is_mul;

  assign is_mul = (mul_op == 2'd1) || (mul_op == 2'd2);
`else
  logic unused_mul_op;
  assign unused_mul_op = ^mul_op;
`endif

  // Next-state and load decode
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = alu_y;
    pc_d    = pc_i;
    rs2_d   = rs2_fwd;
`ifdef EX_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    mul_hi_d = mul_hi_q;
    mpc_d    = mpc_q;
    mrs2_d   = mrs2_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef EX_MUL_EN
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, op1};
            mplier_d = op2;
            acc_d    = '0;
            count_d  = '0;
            mul_hi_d = (mul_op == 2'd2);
            mpc_d    = pc_i;
            mrs2_d   = rs2_fwd;
            state_d  = MUL_BUSY;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
`ifdef EX_MUL_EN
      // One multiplier bit per cycle, LSB first
      MUL_BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (out_free) begin
          load    = 1'b1;
          res_d   = mul_hi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
          pc_d    = mpc_q;
          rs2_d   = mrs2_q;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // EX/MEM register; flush only kills validity, data is don't-care afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      pc_o      <= '0;
      alu_out   <= '0;
      rs2_o     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      pc_o      <= pc_d;
      alu_out   <= res_d;
      rs2_o     <= rs2_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EX_MUL_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      mul_hi_q <= 1'b0;
      mpc_q    <= '0;
      mrs2_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      mul_hi_q <= mul_hi_d;
      mpc_q    <= mpc_d;
      mrs2_q   <= mrs2_d;
    end
  end
`endif
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed self-checking bench for ex_stage_pipe (WIDTH=32); MUL scenarios run when EX_MUL_EN is defined.
`timescale 1ns/1ps

module tb_ex_stage_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  opsel1 = '0, opsel2 = '0, fwd1_sel = '0, fwd2_sel = '0, mul_op = '0;
  logic [3:0]  alu_func = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0, mem_fwd = '0, wb_fwd = '0;
  logic [31:0] pc_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] pc_o, alu_out, rs2_o;

  int total = 0;
  int bad   = 0;

  ex_stage_pipe #(.WIDTH(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opsel1(opsel1), .opsel2(opsel2), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .alu_func(alu_func), .mul_op(mul_op), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .pc_i(pc_i), .out_valid(out_valid),
    .out_ready(out_ready), .pc_o(pc_o), .alu_out(alu_out), .rs2_o(rs2_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] f1,
                          input logic [1:0] f2, input logic [3:0] fn, input logic [1:0] mo,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic [31:0] pc);
    opsel1 = s1; opsel2 = s2; fwd1_sel = f1; fwd2_sel = f2; alu_func = fn; mul_op = mo;
    rs1_data = r1; rs2_data = r2; imm = im; pc_i = pc; in_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({alu_out, pc_o, rs2_o} !== 96'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", alu_out, pc_o, rs2_o); end
    reset = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_alu_add();
    out_ready = 1'b1;
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd5, 32'h55, 32'd7, 32'h1000);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (alu_out !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=c", alu_out); end
    total++; if (pc_o !== 32'h1000) begin bad++; $display("FAIL add_pc got=%h exp=1000", pc_o); end
    total++; if (rs2_o !== 32'h55) begin bad++; $display("FAIL add_rs2 got=%h exp=55", rs2_o); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_forwarding();
    out_ready = 1'b1;
    mem_fwd = 32'h100; wb_fwd = 32'd9;
    drive_op(2'd0, 2'd1, 2'd1, 2'd0, 4'd0, 2'd0, 32'd0, 32'd0, 32'd1, 32'h0);
    tick();
    total++; if (alu_out !== 32'h101) begin bad++; $display("FAIL fwd_mem got=%h exp=101", alu_out); end
    drive_op(2'd0, 2'd0, 2'd0, 2'd2, 4'd0, 2'd0, 32'd3, 32'd77, 32'd0, 32'h0);
    tick();
    total++; if (rs2_o !== 32'd9 || alu_out !== 32'd12) begin bad++; $display("FAIL fwd_wb got=%h/%h exp=9/c", rs2_o, alu_out); end
    // PC + 4 path
    drive_op(2'd1, 2'd2, 2'd0, 2'd0, 4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'h200);
    tick();
    total++; if (alu_out !== 32'h204) begin bad++; $display("FAIL pc_plus4 got=%h exp=204", alu_out); end
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd1, 2'd0, 32'd5, 32'd0, 32'd7, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (alu_out !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_wrap got=%h exp=fffffffe", alu_out); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd1, 32'd0, 32'd1, 32'h10);
    tick();
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd10, 32'd0, 32'd10, 32'h14);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    tick(); tick();
    total++; if (out_valid !== 1'b1 || alu_out !== 32'd2 || pc_o !== 32'h10) begin
      bad++; $display("FAIL bp_hold got=%b/%h/%h exp=1/2/10", out_valid, alu_out, pc_o); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'd20 || pc_o !== 32'h14) begin
      bad++; $display("FAIL bp_second got=%b/%h/%h exp=1/14/14", out_valid, alu_out, pc_o); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd100, 32'd0, 32'(i), 32'(i * 4));
      tick();
      exp_v = 32'd100 + 32'(i);
      total++; if (out_valid !== 1'b1 || alu_out !== exp_v) begin
        bad++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, alu_out, exp_v); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_output();
    out_ready = 1'b0;
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd2, 32'd0, 32'd2, 32'h0);
    tick();
    flush = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input logic [1:0] mo, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_v, input string nm);
    int  cycles;
    logic busy_ready;
    out_ready = 1'b1;
    drive_op(2'd0, 2'd0, 2'd0, 2'd0, 4'd0, mo, a, b, 32'd0, 32'h40);
    tick();
    in_valid = 1'b0;
    cycles = 0; busy_ready = 1'b0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      if (in_ready !== 1'b0) busy_ready = 1'b1;
      tick();
      cycles++;
    end
    total++; if (cycles !== 33) begin bad++; $display("FAIL %s_latency got=%0d exp=33", nm, cycles); end
    total++; if (busy_ready !== 1'b0) begin bad++; $display("FAIL %s_busy_ready got=%b exp=0", nm, busy_ready); end
    total++; if (alu_out !== exp_v || pc_o !== 32'h40) begin
      bad++; $display("FAIL %s_result got=%h/%h exp=%h/40", nm, alu_out, pc_o, exp_v); end
    tick();
  endtask

  task automatic test_mul();
    run_mul(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul");
    run_mul(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_mul(2'd1, 32'd6, 32'd7, 32'd42, "mul_small");
  endtask

  task automatic test_flush_mul();
    logic seen;
    out_ready = 1'b1;
    drive_op(2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd1, 32'd3, 32'd5, 32'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_mul_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_mul_ghost got=%b exp=0", seen); end
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'd8, 32'd0, 32'd9, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'd17) begin
      bad++; $display("FAIL flush_mul_next got=%b/%h exp=1/11", out_valid, alu_out); end
    tick();
  endtask
`else
  task automatic test_mul_ignored();
    out_ready = 1'b1;
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd1, 32'd6, 32'd0, 32'd7, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'd13) begin
      bad++; $display("FAIL mul_ignored got=%b/%h exp=1/d", out_valid, alu_out); end
    tick();
  endtask
`endif

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive_op(2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 32'h11, 32'h44, 32'h22, 32'h300);
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_loaded got=%b exp=1", out_valid); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    total++; if ({out_valid, alu_out, pc_o, rs2_o} !== 97'd0) begin
      bad++; $display("FAIL rst_mid_clear got=%b/%h/%h/%h exp=0", out_valid, alu_out, pc_o, rs2_o); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0", in_ready); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_after got=%b exp=1", in_ready); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_forwarding();
    test_backpressure();
    test_back_to_back();
    test_flush_output();
`ifdef EX_MUL_EN
    test_mul();
    test_flush_mul();
`else
    test_mul_ignored();
`endif
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
